// File: rtl/fp_div_sqrt_arbiter_if.sv
// Request, unit and writeback signals between the FP lanes, the shared
// div/sqrt unit and the FP register-write stage.
interface fp_div_sqrt_arbiter_if #(
    parameter int unsigned FP_ISSUE_WIDTH = 2,
    parameter int unsigned LANE_W         = 1,
    parameter int unsigned TAG_W          = 7
);
    logic [FP_ISSUE_WIDTH-1:0]       req_valid;
    logic [FP_ISSUE_WIDTH-1:0]       req_is_sqrt;
    logic [FP_ISSUE_WIDTH*TAG_W-1:0] req_tag;
    logic [FP_ISSUE_WIDTH-1:0]       req_grant;
    logic                            busy;
    logic                            unit_start;
    logic                            unit_is_sqrt;
    logic                            unit_done;
    logic                            wb_valid;
    logic [LANE_W-1:0]               wb_lane;
    logic [TAG_W-1:0]                wb_tag;
    logic                            wb_ready;
    logic                            flush;
    logic                            wdog_err;

    modport slave (
        input  req_valid, req_is_sqrt, req_tag, unit_done, wb_ready, flush,
        output req_grant, busy, unit_start, unit_is_sqrt, wb_valid, wb_lane, wb_tag, wdog_err
    );

    modport master (
        output req_valid, req_is_sqrt, req_tag, unit_done, wb_ready, flush,
        input  req_grant, busy, unit_start, unit_is_sqrt, wb_valid, wb_lane, wb_tag, wdog_err
    );
endinterface

// File: rtl/fp_div_sqrt_arbiter.sv
// Round-robin arbiter sharing one iterative FP div/sqrt unit among the FP lanes.
// Optional BUSY/DRAIN watchdog: define RSD_FP_DIV_ARB_WATCHDOG_EN.
module fp_div_sqrt_arbiter #(
    parameter int unsigned FP_ISSUE_WIDTH = 2,
    parameter int unsigned LANE_W         = (FP_ISSUE_WIDTH > 1) ? $clog2(FP_ISSUE_WIDTH) : 1,
    parameter int unsigned TAG_W          = 7,
    parameter int unsigned WDOG_LIMIT     = 63
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_div_sqrt_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BUSY  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [LANE_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic                 op_q, op_d;

    logic                      pick_found;
    logic [LANE_W-1:0]         pick_lane;
    logic [LANE_W-1:0]         scan_idx;
    logic [TAG_W-1:0]          pick_tag;
    logic                      pick_sqrt;
    logic [FP_ISSUE_WIDTH-1:0] pick_onehot;
    logic                      grant_en;

    logic [FP_ISSUE_WIDTH-1:0] req_grant;
    logic                      busy;
    logic                      unit_start;
    logic                      unit_is_sqrt;
    logic                      wb_valid;

    if (WDOG_LIMIT == 0 || WDOG_LIMIT > 63) begin : g_bad_wdog_limit
        $error("WDOG_LIMIT must fit the 6-bit watchdog counter");
    end

    // First requesting lane scanning upward from rr_ptr, wrapping around.
    always_comb begin : rr_scan
        pick_found = 1'b0;
        pick_lane  = '0;
        scan_idx   = '0;
        for (int unsigned k = 0; k < FP_ISSUE_WIDTH; k++) begin
            scan_idx = LANE_W'((32'(rr_ptr_q) + k) % FP_ISSUE_WIDTH);
            if (!pick_found && bus.req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_lane  = scan_idx;
            end
        end
    end

    always_comb begin : pick_data
        pick_tag    = '0;
        pick_sqrt   = 1'b0;
        pick_onehot = '0;
        for (int unsigned j = 0; j < FP_ISSUE_WIDTH; j++) begin
            if (pick_lane == LANE_W'(j)) begin
                pick_tag       = bus.req_tag[j*TAG_W +: TAG_W];
                pick_sqrt      = bus.req_is_sqrt[j];
                pick_onehot[j] = 1'b1;
            end
        end
        grant_en = (state_q == S_IDLE) && !bus.flush && pick_found;
    end

    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            lane_q   <= '0;
            tag_q    <= '0;
            op_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            lane_q   <= lane_d;
            tag_q    <= tag_d;
            op_q     <= op_d;
        end
    end

    // unit_done outside BUSY/DRAIN is a protocol violation and is ignored.
    always_comb begin : next_state
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        lane_d   = lane_q;
        tag_d    = tag_q;
        op_d     = op_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant_en) begin
                    state_d = S_START;
                    lane_d  = pick_lane;
                    tag_d   = pick_tag;
                    op_d    = pick_sqrt;
                end
            end
            S_START: state_d = bus.flush ? S_DRAIN : S_BUSY;
            S_BUSY: begin
                if (bus.unit_done) begin
                    state_d = bus.flush ? S_IDLE : S_DONE;
                end else if (bus.flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (bus.wb_ready) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = (lane_q == LANE_W'(FP_ISSUE_WIDTH - 1)) ? '0 : lane_q + LANE_W'(1);
                end
            end
            S_DRAIN: begin
                if (bus.unit_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin : outputs
        req_grant    = '0;
        busy         = 1'b0;
        unit_start   = 1'b0;
        unit_is_sqrt = 1'b0;
        wb_valid     = 1'b0;
        if (grant_en) begin
            req_grant = pick_onehot;
        end
        busy         = (state_q != S_IDLE);
        unit_start   = (state_q == S_START);
        unit_is_sqrt = (state_q != S_IDLE) && op_q;
        wb_valid     = (state_q == S_DONE);
    end

    assign bus.req_grant    = req_grant;
    assign bus.busy         = busy;
    assign bus.unit_start   = unit_start;
    assign bus.unit_is_sqrt = unit_is_sqrt;
    assign bus.wb_valid     = wb_valid;
    assign bus.wb_lane      = lane_q;
    assign bus.wb_tag       = tag_q;

`ifdef RSD_FP_DIV_ARB_WATCHDOG_EN
    localparam int unsigned WDOG_W = 6;

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_err_q, wdog_err_d;
    logic              wdog_waiting;
    logic              wdog_entering;

    // Counts cycles spent waiting on the unit; error is sticky until reset.
    always_comb begin : wdog_next
        wdog_waiting  = (state_q == S_BUSY) || (state_q == S_DRAIN);
        wdog_entering = (state_d != state_q) && ((state_d == S_BUSY) || (state_d == S_DRAIN));
        wdog_cnt_d    = wdog_cnt_q;
        wdog_err_d    = wdog_err_q || (wdog_waiting && (wdog_cnt_q == WDOG_W'(WDOG_LIMIT)));
        if (wdog_entering) begin
            wdog_cnt_d = '0;
        end else if (wdog_waiting && (wdog_cnt_q != WDOG_W'(WDOG_LIMIT))) begin
            wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin : wdog_reg
        if (rst) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign bus.wdog_err = wdog_err_q;
`else
    assign bus.wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_fp_div_sqrt_arbiter.sv
// Bench for fp_div_sqrt_arbiter: directed cycle tables, async reset, and a
// randomized run against a transaction-level model of the shared unit.
module tb_fp_div_sqrt_arbiter;

    localparam int unsigned W  = 2;
    localparam int unsigned TW = 7;
    localparam int          NL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fp_div_sqrt_arbiter_if #(.FP_ISSUE_WIDTH(W), .LANE_W(1), .TAG_W(TW)) bus ();

    fp_div_sqrt_arbiter #(
        .FP_ISSUE_WIDTH(W),
        .LANE_W        (1),
        .TAG_W         (TW),
        .WDOG_LIMIT    (63)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // ctl = {unit_done, wb_ready, flush}; o = {busy, unit_start, unit_is_sqrt, wb_valid}
    typedef struct {
        int         n;
        logic [1:0] rv;
        logic [1:0] sq;
        logic [6:0] t0;
        logic [6:0] t1;
        logic [2:0] ctl;
        logic [1:0] g;
        logic [3:0] o;
        logic       wl;
        logic [6:0] wt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void add(int n, logic [1:0] rv, logic [1:0] sq, logic [6:0] t0,
                                logic [6:0] t1, logic [2:0] ctl, logic [1:0] g,
                                logic [3:0] o, logic wl, logic [6:0] wt);
        vec_t v;
        v.n = n; v.rv = rv; v.sq = sq; v.t0 = t0; v.t1 = t1;
        v.ctl = ctl; v.g = g; v.o = o; v.wl = wl; v.wt = wt;
        tbl.push_back(v);
    endfunction

    function automatic logic [14:0] pk(logic [1:0] g, logic [3:0] o, logic wl, logic [6:0] wt,
                                       logic we);
        return {g, o, o[0] ? {wl, wt} : 8'h00, we};
    endfunction

    function automatic logic [14:0] act_vec();
        return pk(bus.req_grant, {bus.busy, bus.unit_start, bus.unit_is_sqrt, bus.wb_valid},
                  bus.wb_lane, bus.wb_tag, bus.wdog_err);
    endfunction

    task automatic check(string name, logic [14:0] act, logic [14:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic [1:0] rv, logic [1:0] sq, logic [6:0] t0, logic [6:0] t1,
                         logic [2:0] ctl);
        bus.req_valid   = rv;
        bus.req_is_sqrt = sq;
        bus.req_tag     = {t1, t0};
        bus.unit_done   = ctl[2];
        bus.wb_ready    = ctl[1];
        bus.flush       = ctl[0];
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // single request, 10-cycle unit latency
        add(1, 2'b01, 2'b00, 7'h15, 7'h00, 3'b010, 2'b01, 4'b0000, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h15, 7'h00, 3'b010, 2'b00, 4'b1100, 1'b0, 7'h00);
        add(9, 2'b00, 2'b00, 7'h00, 7'h00, 3'b010, 2'b00, 4'b1000, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b110, 2'b00, 4'b1000, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b010, 2'b00, 4'b1001, 1'b0, 7'h15);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b010, 2'b00, 4'b0000, 1'b0, 7'h00);
        // fairness, both lanes requesting; rr_ptr starts at 1
        add(1, 2'b11, 2'b10, 7'h01, 7'h02, 3'b010, 2'b10, 4'b0000, 1'b0, 7'h00);
        add(1, 2'b11, 2'b10, 7'h01, 7'h02, 3'b010, 2'b00, 4'b1110, 1'b0, 7'h00);
        add(1, 2'b11, 2'b10, 7'h01, 7'h02, 3'b110, 2'b00, 4'b1010, 1'b0, 7'h00);
        add(1, 2'b11, 2'b10, 7'h01, 7'h02, 3'b010, 2'b00, 4'b1011, 1'b1, 7'h02);
        add(1, 2'b11, 2'b10, 7'h01, 7'h02, 3'b010, 2'b01, 4'b0000, 1'b0, 7'h00);
        add(1, 2'b11, 2'b10, 7'h01, 7'h02, 3'b010, 2'b00, 4'b1100, 1'b0, 7'h00);
        add(1, 2'b11, 2'b10, 7'h01, 7'h02, 3'b110, 2'b00, 4'b1000, 1'b0, 7'h00);
        add(1, 2'b11, 2'b10, 7'h01, 7'h02, 3'b010, 2'b00, 4'b1001, 1'b0, 7'h01);
        add(1, 2'b11, 2'b10, 7'h01, 7'h02, 3'b010, 2'b10, 4'b0000, 1'b0, 7'h00);
        add(1, 2'b11, 2'b10, 7'h01, 7'h02, 3'b010, 2'b00, 4'b1110, 1'b0, 7'h00);
        add(1, 2'b11, 2'b10, 7'h01, 7'h02, 3'b110, 2'b00, 4'b1010, 1'b0, 7'h00);
        add(1, 2'b11, 2'b10, 7'h01, 7'h02, 3'b010, 2'b00, 4'b1011, 1'b1, 7'h02);
        // backpressure, new request waits until the cycle after wb_ready
        add(1, 2'b01, 2'b00, 7'h33, 7'h00, 3'b000, 2'b01, 4'b0000, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h33, 7'h00, 3'b000, 2'b00, 4'b1100, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b100, 2'b00, 4'b1000, 1'b0, 7'h00);
        add(5, 2'b10, 2'b10, 7'h00, 7'h44, 3'b000, 2'b00, 4'b1001, 1'b0, 7'h33);
        add(1, 2'b10, 2'b10, 7'h00, 7'h44, 3'b010, 2'b00, 4'b1001, 1'b0, 7'h33);
        add(1, 2'b10, 2'b10, 7'h00, 7'h44, 3'b000, 2'b10, 4'b0000, 1'b0, 7'h00);
        // flush 3 cycles after start, unit_done 8 cycles later
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b000, 2'b00, 4'b1110, 1'b0, 7'h00);
        add(2, 2'b00, 2'b00, 7'h00, 7'h00, 3'b000, 2'b00, 4'b1010, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b001, 2'b00, 4'b1010, 1'b0, 7'h00);
        add(3, 2'b01, 2'b00, 7'h00, 7'h00, 3'b000, 2'b00, 4'b1010, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b001, 2'b00, 4'b1010, 1'b0, 7'h00);
        add(3, 2'b00, 2'b00, 7'h00, 7'h00, 3'b000, 2'b00, 4'b1010, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b100, 2'b00, 4'b1010, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b000, 2'b00, 4'b0000, 1'b0, 7'h00);
        // flush with unit_done in BUSY; grant wraps from rr_ptr=1 to lane 0
        add(1, 2'b01, 2'b00, 7'h7f, 7'h00, 3'b000, 2'b01, 4'b0000, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b000, 2'b00, 4'b1100, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b000, 2'b00, 4'b1000, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b101, 2'b00, 4'b1000, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b000, 2'b00, 4'b0000, 1'b0, 7'h00);
        // flush in IDLE blocks grant; flush in START still pulses unit_start
        add(1, 2'b01, 2'b00, 7'h11, 7'h00, 3'b001, 2'b00, 4'b0000, 1'b0, 7'h00);
        add(1, 2'b01, 2'b00, 7'h11, 7'h00, 3'b000, 2'b01, 4'b0000, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b001, 2'b00, 4'b1100, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b100, 2'b00, 4'b1000, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b000, 2'b00, 4'b0000, 1'b0, 7'h00);
        // flush beats wb_ready in DONE and leaves rr_ptr alone
        add(1, 2'b10, 2'b00, 7'h00, 7'h22, 3'b000, 2'b10, 4'b0000, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b000, 2'b00, 4'b1100, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b100, 2'b00, 4'b1000, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b011, 2'b00, 4'b1001, 1'b1, 7'h22);
        add(1, 2'b11, 2'b00, 7'h0a, 7'h0b, 3'b000, 2'b10, 4'b0000, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b000, 2'b00, 4'b1100, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b100, 2'b00, 4'b1000, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b010, 2'b00, 4'b1001, 1'b1, 7'h0b);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b000, 2'b00, 4'b0000, 1'b0, 7'h00);
        // stray unit_done in IDLE, START and DONE has no effect
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b100, 2'b00, 4'b0000, 1'b0, 7'h00);
        add(1, 2'b01, 2'b00, 7'h5a, 7'h00, 3'b000, 2'b01, 4'b0000, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b100, 2'b00, 4'b1100, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b000, 2'b00, 4'b1000, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b100, 2'b00, 4'b1000, 1'b0, 7'h00);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b100, 2'b00, 4'b1001, 1'b0, 7'h5a);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b010, 2'b00, 4'b1001, 1'b0, 7'h5a);
        add(1, 2'b00, 2'b00, 7'h00, 7'h00, 3'b000, 2'b00, 4'b0000, 1'b0, 7'h00);

        drive(2'b00, 2'b00, 7'h00, 7'h00, 3'b000);
        rst = 1'b1;
        #2;
        check("reset outputs", {bus.req_grant, bus.busy, bus.unit_start, bus.unit_is_sqrt,
              bus.wb_valid, bus.wb_lane, bus.wb_tag, bus.wdog_err}, 15'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < tbl.size(); r++) begin
            for (int k = 0; k < tbl[r].n; k++) begin
                @(negedge clk);
                drive(tbl[r].rv, tbl[r].sq, tbl[r].t0, tbl[r].t1, tbl[r].ctl);
                #1;
                check($sformatf("table row %0d cycle %0d", r, k), act_vec(),
                      pk(tbl[r].g, tbl[r].o, tbl[r].wl, tbl[r].wt, 1'b0));
            end
        end

        // async reset while BUSY clears outputs without a clock edge
        @(negedge clk);
        drive(2'b01, 2'b01, 7'h66, 7'h00, 3'b000);
        #1;
        check("async pre grant", act_vec(), pk(2'b01, 4'b0000, 1'b0, 7'h00, 1'b0));
        @(negedge clk);
        drive(2'b00, 2'b00, 7'h00, 7'h00, 3'b000);
        #1;
        check("async pre start", act_vec(), pk(2'b00, 4'b1110, 1'b0, 7'h00, 1'b0));
        @(negedge clk);
        #1;
        check("async pre busy", act_vec(), pk(2'b00, 4'b1010, 1'b0, 7'h00, 1'b0));
        #1;
        rst = 1'b1;
        #1;
        check("async reset mid busy", {bus.req_grant, bus.busy, bus.unit_start, bus.unit_is_sqrt,
              bus.wb_valid, bus.wb_lane, bus.wb_tag, bus.wdog_err}, 15'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_random();
`ifdef RSD_FP_DIV_ARB_WATCHDOG_EN
        run_watchdog();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Model: at most one op in flight; it starts, may be killed, may hold a
    // result awaiting writeback, and leaves when written back or discarded.
    task automatic run_random();
        bit         pend[NL];
        logic [6:0] ptag[NL];
        bit         psq[NL];
        int         rr = 0;
        bit         has_op = 0, started = 0, killed = 0, ready = 0;
        int         ol = 0;
        logic [6:0] ot = '0;
        bit         osq = 0;
        int         ucnt = 0;
        for (int l = 0; l < NL; l++) begin
            pend[l] = 0; ptag[l] = '0; psq[l] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            logic [1:0] eg;
            int         gl;
            bit         fl, rdy, dn;
            @(negedge clk);
            for (int l = 0; l < NL; l++) begin
                if (!pend[l] && $urandom_range(0, 2) == 0) begin
                    pend[l] = 1;
                    ptag[l] = 7'($urandom);
                    psq[l]  = 1'($urandom);
                end
            end
            fl  = ($urandom_range(0, 15) == 0);
            rdy = 1'($urandom_range(0, 1));
            dn  = (ucnt == 1);
            drive({pend[1], pend[0]}, {psq[1], psq[0]}, ptag[0], ptag[1], {dn, rdy, fl});

            eg = '0;
            gl = -1;
            if (!has_op && !fl) begin
                for (int k = 0; k < NL; k++) begin
                    int l;
                    l = (rr + k) % NL;
                    if (gl < 0 && pend[l]) gl = l;
                end
            end
            if (gl >= 0) eg[gl] = 1'b1;
            #1;
            check($sformatf("random cycle %0d", c), act_vec(),
                  pk(eg, {has_op, has_op && !started, has_op && osq, has_op && ready},
                     1'(ol), ot, 1'b0));

            if (ucnt > 0) ucnt--;
            if (gl >= 0) begin
                has_op = 1; started = 0; killed = 0; ready = 0;
                ol = gl; ot = ptag[gl]; osq = psq[gl];
                pend[gl] = 0;
            end else if (has_op) begin
                if (!started) begin
                    started = 1;
                    killed  = fl;
                    ucnt    = $urandom_range(1, 6);
                end else if (ready) begin
                    if (fl) begin
                        has_op = 0;
                    end else if (rdy) begin
                        has_op = 0;
                        rr = (ol + 1) % NL;
                    end
                end else if (dn) begin
                    if (killed || fl) has_op = 0;
                    else ready = 1;
                end else if (fl) begin
                    killed = 1;
                end
            end
        end
        @(negedge clk);
        drive(2'b00, 2'b00, 7'h00, 7'h00, 3'b000);
    endtask

`ifdef RSD_FP_DIV_ARB_WATCHDOG_EN
    task automatic run_watchdog();
        @(negedge clk);
        rst = 1'b1;
        drive(2'b00, 2'b00, 7'h00, 7'h00, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drive(2'b01, 2'b00, 7'h21, 7'h00, 3'b000);
        @(negedge clk);
        drive(2'b00, 2'b00, 7'h00, 7'h00, 3'b000);
        for (int c = 2; c <= 72; c++) begin
            @(negedge clk);
            #1;
            if (c == 40) check("wdog quiet", {14'h0, bus.wdog_err}, 15'h0);
            if (c == 70) check("wdog raised", {14'h0, bus.wdog_err}, 15'h1);
        end
        @(negedge clk);
        drive(2'b00, 2'b00, 7'h00, 7'h00, 3'b100);
        @(negedge clk);
        drive(2'b00, 2'b00, 7'h00, 7'h00, 3'b010);
        @(negedge clk);
        drive(2'b00, 2'b00, 7'h00, 7'h00, 3'b000);
        #1;
        check("wdog sticky", {13'h0, bus.busy, bus.wdog_err}, 15'h1);
    endtask
`endif

endmodule
